counter3_sched: RTL and testbench
=================================

# counter3_sched

Sequencer and two-requester arbiter for the shared 3-bit up counter (`counter3`: active-low enable `nE`, count-by-2 select `cntby2`). Each requester asks the counter to advance from its current value to a target, with a step of 1 or 2. The block grants one requester at a time, rejects targets a step-2 run can never reach, drives `nE`/`cntby2` so the counter stops exactly on the target, and reports `done` or `err`.

## Interface
- `CNT_W`, 3, width of counter value and targets; arithmetic is modulo 2^CNT_W.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  level request per requester; bit 0 is requester 0.
- `by2`  in  2  per-requester step select: 1 means step 2, 0 means step 1.
- `target0`  in  CNT_W  stop value for requester 0.
- `target1`  in  CNT_W  stop value for requester 1.
- `cnt_in`  in  CNT_W  current counter output.
- `gnt`  out  2  one-hot grant; held from the GRANT cycle through the DONE/ERR cycle.
- `done`  out  1  one-cycle pulse; the granted run reached its target.
- `err`  out  1  one-cycle pulse; the target is unreachable, no counting occurred.
- `nE`  out  1  counter enable, active-low.
- `cntby2`  out  1  counter step select.

## Operation
- **States:** IDLE, GRANT, RUN, DONE, ERR.
- **IDLE:** `nE`=1. Eligible requesters have `req`=1 and `served`=0. Any eligible requester selects a winner and the block moves to GRANT. On the transition it latches the target and step and sets `gnt[winner]`.
- **GRANT:** lasts one cycle; `nE`=1, `cntby2`=latched step.
  - If step is 2 and (target − `cnt_in`) is odd, go to ERR.
  - Otherwise go to RUN.
- **RUN:** `nE` = (`cnt_in` == target), combinational. The counter advances each edge until it equals the target, then holds. The block moves to DONE on the edge after the cycle where `cnt_in` == target.
- **DONE / ERR:** one cycle each.
  - `done` or `err` = 1, `gnt` still high, `nE`=1.
  - Next state is IDLE.
  - The winner's `served` flag is set.
- **served[i]:** cleared whenever `req[i]`=0. A requester must drop `req` before it can be granted again. Requesters hold `by2` and target stable while `req` is high.
- **Target equals counter at GRANT:** RUN lasts one cycle with `nE`=1, then DONE. No count occurs.
- **Wrap-around:** distance is computed modulo 2^CNT_W.
  - Step 1 from 5 to 2 passes 5,6,7,0,1,2.
  - Step 2 from 6 to 0 passes 6,0.
- **Counter disturbed externally during RUN** (for example its own reset): the block keeps enabling until `cnt_in` equals the target. A step-2 run may then never finish; this is the system's responsibility.
- **Reset, at any time, takes effect immediately:**
  - state=IDLE, `gnt`=0, `done`=0, `err`=0, `nE`=1, `cntby2`=0.
  - `served`=0, round-robin pointer=0.

## Timing
- `req` sampled high at edge N (block in IDLE): GRANT during cycle N+1, with `gnt` visible.
- First counter increment at the edge ending the first RUN cycle.
- A run of k steps: GRANT 1 + RUN k+1 + DONE 1 = k+3 cycles of `gnt`. `done` is high in the last of these cycles.
- Error path: `gnt` high 2 cycles (GRANT, ERR); `err` high in the second.
- Minimum spacing between grants is one IDLE cycle.

## Configuration
- `COUNTER3_SCHED_RR_EN` defined:
  - Round-robin arbitration using a 1-bit pointer that prefers the requester not most recently granted.
  - The pointer updates on each grant.
  - With both eligible and pointer=0, requester 0 wins.
- Undefined:
  - Fixed priority; requester 0 always wins when eligible.
  - No pointer register.

## Structure
- Package `counter3_sched_pkg`:
  - state enum type (IDLE, GRANT, RUN, DONE, ERR).
  - `STEP1`/`STEP2` constants.
  - default `CNT_W`.
- Sub-module `counter3_sched_arb`:
  - inputs: eligible vector, pointer, grant strobe.
  - output: one-hot winner.
  - Contains the `COUNTER3_SCHED_RR_EN` logic.

## Test plan
- Reset asserted mid-RUN (counter at 3, target 6) → next cycle: `gnt`=00, `nE`=1, state IDLE, `done`/`err` never pulse.
- `req`=01, `by2`=0, `cnt_in`=0, `target0`=5 → `gnt`=01 for 8 cycles, counter ends at 5, `done` pulses once in cycle 8.
- `req`=10, `by2`=10, `cnt_in`=6, `target1`=0 → counter goes 6 → 0 with `cntby2`=1, `done` after 4 `gnt` cycles.
- `by2`=01, `cnt_in`=2, `target0`=5 → `err` pulses in the second `gnt` cycle, `nE` never low, counter unchanged.
- Both `req` held high continuously, each dropping `req` for 1 cycle after its `done`:
  - With RR_EN: grants alternate 0,1,0.
  - Without RR_EN: requester 0 is re-granted each time it is eligible.
- `target0` == `cnt_in`=3 → `done` after 3 `gnt` cycles, no increment.

Source files
------------

// File: rtl/counter3_sched_pkg.sv
// Shared types and constants for the counter3 sequencer/arbiter.
package counter3_sched_pkg;

  localparam int unsigned CNT_W_DEF = 3;

  localparam logic STEP1 = 1'b0;
  localparam logic STEP2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/counter3_sched_arb.sv
// Two-requester arbiter. Define COUNTER3_SCHED_RR_EN for round-robin
// (pointer prefers the requester not most recently granted); otherwise
// fixed priority with requester 0 first.
module counter3_sched_arb (
  input  logic [1:0] elig_i,
  input  logic       ptr_i,
  input  logic       stb_i,
  output logic [1:0] win_o
);

`ifdef COUNTER3_SCHED_RR_EN
  // Round-robin pick: only a tie consults the pointer.
  always_comb begin
    win_o = '0;
    if (stb_i) begin
      if (elig_i == 2'b11) begin
        win_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        win_o = elig_i;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  // Fixed priority pick: requester 0 wins whenever eligible.
  always_comb begin
    win_o = '0;
    if (stb_i) begin
      if (elig_i[0]) begin
        win_o = 2'b01;
      end else if (elig_i[1]) begin
        win_o = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/counter3_sched.sv
// Sequencer and two-requester arbiter for the shared counter3. Grants one
// requester, rejects step-2 targets of odd distance, enables the counter
// until it reaches the target, then pulses done or err.
// Optional feature: COUNTER3_SCHED_RR_EN selects round-robin arbitration.
module counter3_sched
  import counter3_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       req,
  input  logic [1:0]       by2,
  input  logic [CNT_W-1:0] target0,
  input  logic [CNT_W-1:0] target1,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             err,
  output logic             nE,
  output logic             cntby2
);

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             step_q, step_d;
  logic [1:0]       served_q, served_d;
  logic             ptr;
  logic [1:0]       elig;
  logic [1:0]       win;
  logic             stb;
  logic             at_tgt;

  assign elig   = req & ~served_q;
  assign stb    = (state_q == ST_IDLE) && (elig != 2'b00);
  assign at_tgt = (cnt_in == tgt_q);

  counter3_sched_arb u_arb (
    .elig_i (elig),
    .ptr_i  (ptr),
    .stb_i  (stb),
    .win_o  (win)
  );

`ifdef COUNTER3_SCHED_RR_EN
  logic ptr_q;
  assign ptr = ptr_q;

  // Pointer moves to the other requester after every grant.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= 1'b0;
    end else if (stb) begin
      ptr_q <= win[0];
    end
  end
`else
  assign ptr = 1'b0;
`endif

  // Next-state, grant latching and served bookkeeping.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    served_d = served_q & req;
    case (state_q)
      ST_IDLE: begin
        if (stb) begin
          state_d = ST_GRANT;
          gnt_d   = win;
          tgt_d   = win[1] ? target1 : target0;
          step_d  = win[1] ? by2[1] : by2[0];
        end
      end
      ST_GRANT: begin
        // Distance parity equals the XOR of the LSBs (modulus is even).
        if ((step_q == STEP2) && (tgt_q[0] ^ cnt_in[0])) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (at_tgt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        served_d = (served_q | gnt_q) & req;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      tgt_q    <= '0;
      step_q   <= STEP1;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      served_q <= served_d;
    end
  end

  // Outputs; nE in RUN follows the live counter value.
  always_comb begin
    gnt    = gnt_q;
    done   = (state_q == ST_DONE);
    err    = (state_q == ST_ERR);
    nE     = (state_q == ST_RUN) ? at_tgt : 1'b1;
    cntby2 = ((state_q == ST_GRANT) || (state_q == ST_RUN)) ? step_q : STEP1;
  end

endmodule

// File: tb/tb_counter3_sched.sv
// Self-checking bench for counter3_sched with a behavioural counter3 model.
module tb_counter3_sched;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] req;
  logic [1:0] by2;
  logic [2:0] target0, target1;
  logic [2:0] cnt;
  logic [1:0] gnt;
  logic       done, err, nE, cntby2;

  logic       cnt_load;
  logic [2:0] cnt_init;

  typedef struct {
    logic [1:0] gnt;
    int         cyc;
    int         nel;
    logic       is_err;
    logic [2:0] fin;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    logic [1:0] by2;
    logic [2:0] t0;
    logic [2:0] t1;
    logic [2:0] c0;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  counter3_sched #(.CNT_W(3)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     (req),
    .by2     (by2),
    .target0 (target0),
    .target1 (target1),
    .cnt_in  (cnt),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .nE      (nE),
    .cntby2  (cntby2)
  );

  // counter3 model: active-low enable, step 1 or 2, bench-side load.
  always @(posedge Clk) begin
    if (cnt_load) cnt <= cnt_init;
    else if (!nE) cnt <= cnt + (cntby2 ? 3'd2 : 3'd1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mke(input logic [1:0] g, input int c, input int n,
                               input logic e, input logic [2:0] f);
    exp_t r;
    r.gnt = g; r.cyc = c; r.nel = n; r.is_err = e; r.fin = f;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [1:0] rq, input logic [1:0] b,
                               input logic [2:0] t0, input logic [2:0] t1,
                               input logic [2:0] c0, input exp_t e);
    vec_t v;
    v.req = rq; v.by2 = b; v.t0 = t0; v.t1 = t1; v.c0 = c0; v.e = e;
    return v;
  endfunction

  // Scoreboard monitor: counts grant cycles and enable-low cycles, and
  // compares against the queued expectation on every done/err pulse.
  initial begin
    int   mcyc;
    int   mnel;
    exp_t e;
    mcyc = 0;
    mnel = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        mcyc = 0;
        mnel = 0;
      end else begin
        if (gnt != 2'b00) begin
          mcyc++;
          if (!nE) mnel++;
        end
        if (done || err) begin
          if (sbq.size() == 0) begin
            check("unexpected_pulse", {done, err}, 0);
          end else begin
            e = sbq.pop_front();
            check("gnt_at_end", gnt, e.gnt);
            check("gnt_cycles", mcyc, e.cyc);
            check("enable_cycles", mnel, e.nel);
            check("err_flag", err, e.is_err);
            check("done_flag", done, !e.is_err);
            check("final_count", cnt, e.fin);
          end
          mcyc = 0;
          mnel = 0;
        end
      end
    end
  end

  task automatic wait_pulse(input string name);
    int t;
    t = 0;
    do begin
      @(negedge Clk);
      t++;
    end while (!(done || err) && t < 64);
    if (!(done || err)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no done/err within %0d cycles, required within 64", name, t);
      sbq.delete();
      req   = 2'b00;
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  localparam int NV = 10;
  vec_t vt[NV];

  initial begin
    logic [1:0] w;
    int         t;

    vt[0] = mkv(2'b01, 2'b00, 3'd5, 3'd1, 3'd0, mke(2'b01,  8, 5, 1'b0, 3'd5));
    vt[1] = mkv(2'b10, 2'b10, 3'd3, 3'd0, 3'd6, mke(2'b10,  4, 1, 1'b0, 3'd0));
    vt[2] = mkv(2'b01, 2'b01, 3'd5, 3'd4, 3'd2, mke(2'b01,  2, 0, 1'b1, 3'd2));
    vt[3] = mkv(2'b01, 2'b00, 3'd3, 3'd6, 3'd3, mke(2'b01,  3, 0, 1'b0, 3'd3));
    vt[4] = mkv(2'b01, 2'b00, 3'd2, 3'd7, 3'd5, mke(2'b01,  8, 5, 1'b0, 3'd2));
    vt[5] = mkv(2'b10, 2'b00, 3'd7, 3'd6, 3'd7, mke(2'b10, 10, 7, 1'b0, 3'd6));
    vt[6] = mkv(2'b10, 2'b10, 3'd4, 3'd1, 3'd1, mke(2'b10,  3, 0, 1'b0, 3'd1));
    vt[7] = mkv(2'b01, 2'b01, 3'd2, 3'd3, 3'd4, mke(2'b01,  6, 3, 1'b0, 3'd2));
    vt[8] = mkv(2'b10, 2'b10, 3'd6, 3'd7, 3'd0, mke(2'b10,  2, 0, 1'b1, 3'd0));
    vt[9] = mkv(2'b01, 2'b10, 3'd5, 3'd0, 3'd2, mke(2'b01,  6, 3, 1'b0, 3'd5));

    Reset    = 1'b1;
    req      = 2'b00;
    by2      = 2'b00;
    target0  = 3'd0;
    target1  = 3'd0;
    cnt_load = 1'b1;
    cnt_init = 3'd0;
    repeat (2) @(negedge Clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_nE", nE, 1);
    check("rst_cntby2", cntby2, 0);
    Reset    = 1'b0;
    cnt_load = 1'b0;
    @(negedge Clk);

    // Single-requester table.
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      req      = 2'b00;
      by2      = vt[i].by2;
      target0  = vt[i].t0;
      target1  = vt[i].t1;
      cnt_init = vt[i].c0;
      cnt_load = 1'b1;
      @(negedge Clk);
      cnt_load = 1'b0;
      @(negedge Clk);
      sbq.push_back(vt[i].e);
      req = vt[i].req;
      @(negedge Clk);
      check("grant_latency", gnt, vt[i].req);
      wait_pulse("vector_run");
    end

    // Reset in the middle of a run: counter at 3 heading for 6.
    @(negedge Clk);
    req      = 2'b00;
    by2      = 2'b00;
    target0  = 3'd6;
    cnt_init = 3'd3;
    cnt_load = 1'b1;
    @(negedge Clk);
    cnt_load = 1'b0;
    @(negedge Clk);
    req = 2'b01;
    t = 0;
    do begin
      @(negedge Clk);
      t++;
    end while (!(gnt == 2'b01 && !nE && cnt == 3'd3) && t < 16);
    check("midrun_reached", (gnt == 2'b01 && !nE && cnt == 3'd3), 1);
    req   = 2'b00;
    Reset = 1'b1;
    #1;
    check("midrun_rst_gnt", gnt, 0);
    check("midrun_rst_nE", nE, 1);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_err", err, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("midrun_post_gnt", gnt, 0);
    check("midrun_post_cnt", cnt, 3);

    // Both requesters held high, each dropping req for one clock after done.
    pulse_reset();
    by2      = 2'b00;
    target0  = 3'd2;
    target1  = 3'd5;
    cnt_init = 3'd0;
    cnt_load = 1'b1;
    @(negedge Clk);
    cnt_load = 1'b0;
`ifdef COUNTER3_SCHED_RR_EN
    sbq.push_back(mke(2'b01, 5, 2, 1'b0, 3'd2));
    sbq.push_back(mke(2'b10, 6, 3, 1'b0, 3'd5));
    sbq.push_back(mke(2'b01, 8, 5, 1'b0, 3'd2));
`else
    sbq.push_back(mke(2'b01, 5, 2, 1'b0, 3'd2));
    sbq.push_back(mke(2'b01, 3, 0, 1'b0, 3'd2));
    sbq.push_back(mke(2'b01, 3, 0, 1'b0, 3'd2));
`endif
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_pulse("arb_run");
      w   = gnt;
      req = req & ~w;
      @(posedge Clk);
      #1;
      if (k < 2) req = req | w;
      else req = 2'b00;
    end
    repeat (3) @(negedge Clk);
    check("arb_queue_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
